// File: rtl/matrix3x3_calculator.sv
// Single-cycle unsigned 3x3 matrix multiplier: R = A x B, registered.
// All nine dot products are formed combinationally from the current
// operands and captured together on an enabled clock edge. Results wrap
// modulo 2^16 and hold until the next enabled edge or reset.
module matrix3x3_calculator (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_multiplication,
  input  logic [15:0] A00, input logic [15:0] A01, input logic [15:0] A02,
  input  logic [15:0] A10, input logic [15:0] A11, input logic [15:0] A12,
  input  logic [15:0] A20, input logic [15:0] A21, input logic [15:0] A22,
  input  logic [15:0] B00, input logic [15:0] B01, input logic [15:0] B02,
  input  logic [15:0] B10, input logic [15:0] B11, input logic [15:0] B12,
  input  logic [15:0] B20, input logic [15:0] B21, input logic [15:0] B22,
  output logic [15:0] R00, output logic [15:0] R01, output logic [15:0] R02,
  output logic [15:0] R10, output logic [15:0] R11, output logic [15:0] R12,
  output logic [15:0] R20, output logic [15:0] R21, output logic [15:0] R22
);

  logic [15:0] a [3][3];
  logic [15:0] b [3][3];
  logic [15:0] prod [3][3];
  logic [15:0] r_q  [3][3];

  // One row-by-column dot product: full 32-bit products, 34-bit sum,
  // truncated to the low 16 bits (no saturation).
  function automatic logic [15:0] dot3(
    input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
    input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2
  );
    logic [31:0] p0, p1, p2;
    logic [33:0] sum;
    p0  = 32'(a0) * 32'(b0);
    p1  = 32'(a1) * 32'(b1);
    p2  = 32'(a2) * 32'(b2);
    sum = 34'(p0) + 34'(p1) + 34'(p2);
    return sum[15:0];
  endfunction

  assign a[0][0] = A00; assign a[0][1] = A01; assign a[0][2] = A02;
  assign a[1][0] = A10; assign a[1][1] = A11; assign a[1][2] = A12;
  assign a[2][0] = A20; assign a[2][1] = A21; assign a[2][2] = A22;

  assign b[0][0] = B00; assign b[0][1] = B01; assign b[0][2] = B02;
  assign b[1][0] = B10; assign b[1][1] = B11; assign b[1][2] = B12;
  assign b[2][0] = B20; assign b[2][1] = B21; assign b[2][2] = B22;

  for (genvar i = 0; i < 3; i++) begin : g_row
    for (genvar j = 0; j < 3; j++) begin : g_col
      assign prod[i][j] = dot3(a[i][0], a[i][1], a[i][2],
                               b[0][j], b[1][j], b[2][j]);
    end
  end

  // Result register: reset clears all nine, enable loads all nine, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result array is only nine registers, so it is cleared in
      // full on reset; a large RAM-style array would normally be left unreset.
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_q[i][j] <= '0;
    end else if (enable_multiplication) begin
      // NOTE: non-blocking so every register samples pre-edge values and
      // no ordering dependency exists between the nine updates.
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_q[i][j] <= prod[i][j];
    end
  end

  assign R00 = r_q[0][0]; assign R01 = r_q[0][1]; assign R02 = r_q[0][2];
  assign R10 = r_q[1][0]; assign R11 = r_q[1][1]; assign R12 = r_q[1][2];
  assign R20 = r_q[2][0]; assign R21 = r_q[2][1]; assign R22 = r_q[2][2];

endmodule

// File: tb/tb_matrix3x3_calculator.sv
// Directed testbench for matrix3x3_calculator with hand-computed results.
module tb_matrix3x3_calculator;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [0:8][15:0] av;
  logic [0:8][15:0] bv;
  wire  [15:0] r [9];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix3x3_calculator dut (
    .clk(clk), .rst(rst), .enable_multiplication(en),
    .A00(av[0]), .A01(av[1]), .A02(av[2]),
    .A10(av[3]), .A11(av[4]), .A12(av[5]),
    .A20(av[6]), .A21(av[7]), .A22(av[8]),
    .B00(bv[0]), .B01(bv[1]), .B02(bv[2]),
    .B10(bv[3]), .B11(bv[4]), .B12(bv[5]),
    .B20(bv[6]), .B21(bv[7]), .B22(bv[8]),
    .R00(r[0]), .R01(r[1]), .R02(r[2]),
    .R10(r[3]), .R11(r[4]), .R12(r[5]),
    .R20(r[6]), .R21(r[7]), .R22(r[8])
  );

  // Advance one rising edge and settle 1 ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare all nine outputs against an expected matrix (row-major).
  task automatic check(input string tag, input logic [0:8][15:0] exp);
    for (int k = 0; k < 9; k++) begin
      checks++;
      assert (r[k] === exp[k])
      else begin
        errors++;
        $error("FAIL %s R%0d%0d observed %h expected %h",
               tag, k / 3, k % 3, r[k], exp[k]);
      end
    end
  endtask

  localparam logic [0:8][15:0] M_ZERO = '0;
  localparam logic [0:8][15:0] M_IDENT =
    {16'd1, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0, 16'd1};
  localparam logic [0:8][15:0] M_B1 =
    {16'd2, 16'd3, 16'd4, 16'd1, 16'd0, 16'd6, 16'd7, 16'd5, 16'd1};
  localparam logic [0:8][15:0] M_GA =
    {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8, 16'd9};
  localparam logic [0:8][15:0] M_GB =
    {16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1};
  localparam logic [0:8][15:0] M_GR =
    {16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54, 16'd138, 16'd114, 16'd90};

  logic [0:8][15:0] exp_m;

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    av  = M_GA;
    bv  = M_GB;

    // Reset with enable high and nonzero operands: reset wins.
    step();
    check("reset", M_ZERO);

    // Identity x B.
    rst = 1'b0;
    av  = M_IDENT;
    bv  = M_B1;
    step();
    check("identity", M_B1);

    // General multiply.
    av = M_GA;
    bv = M_GB;
    step();
    check("general", M_GR);

    // Zero A.
    av = M_ZERO;
    step();
    check("zero", M_ZERO);

    // 0xFFFF * 0xFFFF = 0xFFFE0001 -> low half 0x0001.
    av = M_ZERO; av[0] = 16'hFFFF;
    bv = M_ZERO; bv[0] = 16'hFFFF;
    step();
    exp_m = M_ZERO; exp_m[0] = 16'h0001;
    check("wrap_ffff", exp_m);

    // 3 * (0x8000 * 2) = 0x30000 -> low half 0x0000.
    av = M_ZERO; av[0] = 16'h8000; av[1] = 16'h8000; av[2] = 16'h8000;
    bv = M_ZERO; bv[0] = 16'h0002; bv[3] = 16'h0002; bv[6] = 16'h0002;
    step();
    check("wrap_sum", M_ZERO);

    // Load general result, then hold for 3 cycles with changing inputs.
    av = M_GA;
    bv = M_GB;
    step();
    check("hold_load", M_GR);
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 9; k++) begin
        av[k] = 16'($urandom);
        bv[k] = 16'($urandom);
      end
      step();
      check("hold", M_GR);
    end

    // Re-raise enable: updates on the next edge.
    en = 1'b1;
    av = M_IDENT;
    bv = M_B1;
    step();
    check("reenable", M_B1);

    // Reset in the middle of an enabled stream discards that edge.
    rst = 1'b1;
    av  = M_GA;
    bv  = M_GB;
    step();
    check("reset_stream", M_ZERO);
    rst = 1'b0;
    step();
    check("after_reset", M_GR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
